// File: rtl/scan_sched_pkg.sv
// Shared encodings for the scan scheduler: top-level FSM states, detector
// states and the searched bit pattern.
package scan_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

  typedef enum logic [1:0] {
    DET_S0   = 2'd0,
    DET_S1   = 2'd1,
    DET_S10  = 2'd2,
    DET_S100 = 2'd3
  } det_state_t;

  localparam logic [3:0] PATTERN        = 4'b1001;
  localparam logic [3:0] FIRST_POS_NONE = 4'hF;

endpackage

// File: rtl/scan_sched_if.sv
// Job request / grant / result bundle between requesters and scan_sched.
interface scan_sched_if #(
  parameter int WIDTH = 8
) ();

  logic [1:0]       req;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [1:0]       gnt;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [3:0]       match_cnt;

  modport master (
    output req, data0, data1,
    input  gnt, busy, done, done_id, match_cnt
  );

  modport slave (
    input  req, data0, data1,
    output gnt, busy, done, done_id, match_cnt
  );

endinterface

// File: rtl/seq1001_det.sv
// Mealy detector for 1001 with overlap; clr returns it to the start state
// synchronously so matches never straddle two jobs.
//   state    | meaning
//   DET_S0   | nothing useful seen
//   DET_S1   | seen "1"
//   DET_S10  | seen "10"
//   DET_S100 | seen "100"; a 1 now completes a match
module seq1001_det
  import scan_sched_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic x,
  output logic z
);

  det_state_t r_state;
  det_state_t w_next;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   r_state <= DET_S0;
    else if (clr) r_state <= DET_S0;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = DET_S0;
    z      = 1'b0;
    case (r_state)
      DET_S0:   w_next = (x == PATTERN[3]) ? DET_S1   : DET_S0;
      DET_S1:   w_next = (x == PATTERN[2]) ? DET_S10  : DET_S1;
      DET_S10:  w_next = (x == PATTERN[1]) ? DET_S100 : DET_S1;
      DET_S100: begin
        // the closing 1 also starts the next candidate match
        if (x == PATTERN[0]) begin
          z      = 1'b1;
          w_next = DET_S1;
        end else begin
          w_next = DET_S0;
        end
      end
      default:  w_next = DET_S0;
    endcase
  end

endmodule

// File: rtl/scan_sched.sv
// Round-robin two-requester scheduler that counts 1001 matches in a job word.
// Optional SCAN_FIRST_POS_EN adds first_pos (index of the first match).
//   state   | meaning
//   ST_IDLE | waiting for a request; grant issued here
//   ST_SCAN | feeding one bit per cycle, MSB first
//   ST_DONE | one-cycle result pulse
module scan_sched
  import scan_sched_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  scan_sched_if.slave  bus
`ifdef SCAN_FIRST_POS_EN
  , output logic [3:0] first_pos
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);

  sched_state_t     r_state;
  sched_state_t     w_next;
  logic [1:0]       w_gnt;
  logic             w_win;
  logic             w_grant;
  logic             w_last_bit;
  logic             w_x;
  logic             w_z;

  logic [WIDTH-1:0] r_data;
  logic             r_id;
  logic             r_last;
  logic [3:0]       r_idx;
  logic [3:0]       r_cnt;
  logic             r_done_id;
  logic [3:0]       r_match_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_gnt  = 2'b00;
    // on a tie the requester not served last wins
    w_win  = (bus.req == 2'b11) ? ~r_last : bus.req[1];
    case (r_state)
      ST_IDLE: begin
        if (reset && (|bus.req)) begin
          w_gnt  = w_win ? 2'b10 : 2'b01;
          w_next = ST_SCAN;
        end
      end
      ST_SCAN: if (r_idx == LAST_IDX) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_grant    = |w_gnt;
  assign w_last_bit = (r_state == ST_SCAN) && (r_idx == LAST_IDX);
  assign w_x        = (r_state == ST_SCAN) && r_data[WIDTH-1];

  assign bus.gnt       = w_gnt;
  assign bus.busy      = (r_state == ST_SCAN) || (r_state == ST_DONE);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.done_id   = r_done_id;
  assign bus.match_cnt = r_match_cnt;

  seq1001_det u_det (
    .clock (clock),
    .reset (reset),
    .clr   (w_grant),
    .x     (w_x),
    .z     (w_z)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data      <= '0;
      r_id        <= 1'b0;
      r_last      <= 1'b1;
      r_idx       <= 4'd0;
      r_cnt       <= 4'd0;
      r_done_id   <= 1'b0;
      r_match_cnt <= 4'd0;
    end else if (w_grant) begin
      r_data <= w_win ? bus.data1 : bus.data0;
      r_id   <= w_win;
      r_last <= w_win;
      r_idx  <= 4'd0;
      r_cnt  <= 4'd0;
    end else if (r_state == ST_SCAN) begin
      r_data <= r_data << 1;
      r_idx  <= r_idx + 4'd1;
      r_cnt  <= r_cnt + {3'b000, w_z};
      // results only move on the last bit so they hold outside DONE
      if (w_last_bit) begin
        r_match_cnt <= r_cnt + {3'b000, w_z};
        r_done_id   <= r_id;
      end
    end
  end

`ifdef SCAN_FIRST_POS_EN
  logic [3:0] r_fp;
  logic [3:0] r_first_pos;
  logic       w_first_hit;

  assign w_first_hit = w_z && (r_fp == FIRST_POS_NONE);
  assign first_pos   = r_first_pos;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fp        <= FIRST_POS_NONE;
      r_first_pos <= FIRST_POS_NONE;
    end else if (w_grant) begin
      r_fp <= FIRST_POS_NONE;
    end else if (r_state == ST_SCAN) begin
      if (w_first_hit) r_fp <= r_idx;
      if (w_last_bit)  r_first_pos <= w_first_hit ? r_idx : r_fp;
    end
  end
`endif

endmodule

// File: tb/tb_scan_sched.sv
// Directed bench for scan_sched: reset values, arbitration, latency, match
// counts, detector clear between jobs, mid-scan reset and ignored requests.
module tb_scan_sched;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  scan_sched_if #(.WIDTH(8)) bus ();

`ifdef SCAN_FIRST_POS_EN
  logic [3:0] first_pos;
`endif

  scan_sched #(.WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef SCAN_FIRST_POS_EN
    , .first_pos (first_pos)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called #1 after a rising edge with the DUT in IDLE; returns #1 after the
  // edge that leaves DONE.
  task automatic job(input string tag, input logic [1:0] r, input logic [7:0] d0,
                     input logic [7:0] d1, input logic [1:0] exp_gnt, input logic exp_id,
                     input logic [3:0] exp_cnt, input logic [3:0] exp_fp,
                     input logic [1:0] r_after, input logic toggle1);
    bus.req   = r;
    bus.data0 = d0;
    bus.data1 = d1;
    @(negedge clock);
    check({tag, ".gnt"},  {6'd0, bus.gnt}, {6'd0, exp_gnt});
    check({tag, ".busy0"}, {7'd0, bus.busy}, 8'd0);
    tick();
    bus.req = r_after;
    for (int i = 0; i < 8; i++) begin
      if (toggle1) begin
        bus.req[1] = ~bus.req[1];
        bus.data1  = ~bus.data1;
      end
      @(negedge clock);
      check($sformatf("%s.scan%0d.busy", tag, i), {7'd0, bus.busy}, 8'd1);
      check($sformatf("%s.scan%0d.gnt", tag, i),  {6'd0, bus.gnt},  8'd0);
      check($sformatf("%s.scan%0d.done", tag, i), {7'd0, bus.done}, 8'd0);
      tick();
    end
    @(negedge clock);
    check({tag, ".done"},    {7'd0, bus.done},      8'd1);
    check({tag, ".busy_d"},  {7'd0, bus.busy},      8'd1);
    check({tag, ".done_id"}, {7'd0, bus.done_id},   {7'd0, exp_id});
    check({tag, ".cnt"},     {4'd0, bus.match_cnt}, {4'd0, exp_cnt});
`ifdef SCAN_FIRST_POS_EN
    check({tag, ".fpos"},    {4'd0, first_pos},     {4'd0, exp_fp});
`endif
    tick();
    check({tag, ".idle_done"}, {7'd0, bus.done},      8'd0);
    check({tag, ".idle_busy"}, {7'd0, bus.busy},      8'd0);
    check({tag, ".hold_cnt"},  {4'd0, bus.match_cnt}, {4'd0, exp_cnt});
    check({tag, ".hold_id"},   {7'd0, bus.done_id},   {7'd0, exp_id});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    bus.req   = 2'b00;
    bus.data0 = 8'h00;
    bus.data1 = 8'h00;

    repeat (2) @(posedge clock);
    #1;
    bus.req = 2'b11;
    @(negedge clock);
    check("rst.gnt",  {6'd0, bus.gnt},       8'd0);
    check("rst.busy", {7'd0, bus.busy},      8'd0);
    check("rst.done", {7'd0, bus.done},      8'd0);
    check("rst.id",   {7'd0, bus.done_id},   8'd0);
    check("rst.cnt",  {4'd0, bus.match_cnt}, 8'd0);
`ifdef SCAN_FIRST_POS_EN
    check("rst.fpos", {4'd0, first_pos},     8'h0F);
`endif
    bus.req = 2'b00;
    tick();
    reset = 1'b1;

    job("sole0", 2'b01, 8'b1001_0010, 8'h00, 2'b01, 1'b0, 4'd2, 4'd3, 2'b00, 1'b0);

    reset = 1'b0;
    #2;
    reset = 1'b1;
    job("tie_a", 2'b11, 8'b1001_1001, 8'hFF, 2'b01, 1'b0, 4'd2, 4'd3, 2'b10, 1'b0);
    job("tie_b", 2'b10, 8'b1001_1001, 8'hFF, 2'b10, 1'b1, 4'd0, 4'hF, 2'b00, 1'b0);
    job("ovl",   2'b01, 8'b1001_1001, 8'h00, 2'b01, 1'b0, 4'd2, 4'd3, 2'b00, 1'b0);
    job("clr",   2'b01, 8'b0010_0000, 8'h00, 2'b01, 1'b0, 4'd0, 4'hF, 2'b00, 1'b0);
    job("rr1",   2'b11, 8'b0100_1001, 8'b0000_1001, 2'b10, 1'b1, 4'd1, 4'd7, 2'b01, 1'b0);
    job("rr0",   2'b01, 8'b0100_1001, 8'h00, 2'b01, 1'b0, 4'd2, 4'd4, 2'b00, 1'b0);
    job("tog",   2'b10, 8'h00, 8'b1001_0010, 2'b10, 1'b1, 4'd2, 4'd3, 2'b00, 1'b1);

    // abort a job part-way through SCAN
    bus.req   = 2'b01;
    bus.data0 = 8'b1001_1001;
    @(negedge clock);
    check("abort.gnt", {6'd0, bus.gnt}, 8'd1);
    tick();
    bus.req = 2'b00;
    repeat (4) tick();
    bus.req = 2'b01;
    reset   = 1'b0;
    #1;
    check("abort.busy", {7'd0, bus.busy},      8'd0);
    check("abort.done", {7'd0, bus.done},      8'd0);
    check("abort.gnt0", {6'd0, bus.gnt},       8'd0);
    check("abort.cnt",  {4'd0, bus.match_cnt}, 8'd0);
    check("abort.id",   {7'd0, bus.done_id},   8'd0);
`ifdef SCAN_FIRST_POS_EN
    check("abort.fpos", {4'd0, first_pos},     8'h0F);
`endif
    tick();
    @(negedge clock);
    check("abort.hold_done", {7'd0, bus.done}, 8'd0);
    check("abort.hold_gnt",  {6'd0, bus.gnt},  8'd0);
    tick();
    reset = 1'b1;
    job("rerq", 2'b01, 8'b1001_1001, 8'h00, 2'b01, 1'b0, 4'd2, 4'd3, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_sched.md
SCAN_SCHED -- requirements
Module: scan_sched

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, bits per job word; legal range 4..15.
REQ-002 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port: req  input  2  per-requester job request; held high until granted.
REQ-005 SHALL have port: data0  input  WIDTH  requester 0 job word; stable while req[0]=1.
REQ-006 SHALL have port: data1  input  WIDTH  requester 1 job word; stable while req[1]=1.
REQ-007 SHALL have port: gnt  output  2  one-hot, one-cycle grant pulse; data captured that cycle.
REQ-008 SHALL have port: busy  output  1  high in SCAN and DONE states.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port: done_id  output  1  requester index of the completed job; valid with done.
REQ-011 SHALL have port: match_cnt  output  4  number of pattern matches in the job; valid with done.

Function
REQ-012 SHALL implement FSM IDLE -> SCAN -> DONE -> IDLE.
REQ-013 In IDLE with any req bit high, SHALL pulse gnt for the winner, capture its data word and id, clear the bit index, detector state and match counter, and enter SCAN on the next edge.
REQ-014 Arbitration SHALL be round-robin: a sole requester always wins; on a tie, the requester not served last wins; after reset, requester 0 wins the first tie.
REQ-015 In SCAN, SHALL feed one bit per cycle, MSB first, into the detector for exactly WIDTH cycles; bit index i (0 = MSB) is fed in SCAN cycle i.
REQ-016 The detector SHALL be a Mealy machine for pattern 1001 with overlap allowed: z=1 combinationally in the cycle the final 1 is presented.
REQ-017 Each cycle with z=1 SHALL increment match_cnt at that edge; no saturation is needed because the maximum count is 4 for WIDTH<=15.
REQ-018 Detector state SHALL be cleared at every grant, so matches never span two jobs.
REQ-019 DONE SHALL last one cycle with done=1, done_id and match_cnt valid, then return to IDLE; a new grant is possible in the cycle after DONE.
REQ-020 Latency SHALL be: the gnt cycle is followed by WIDTH SCAN cycles and then the DONE cycle (done at gnt+WIDTH+1).
REQ-021 req changes during SCAN or DONE SHALL be ignored; no gnt is issued while busy=1.
REQ-022 gnt, done and busy SHALL be 0 in IDLE; match_cnt and done_id SHALL hold their last values outside DONE.

Reset
REQ-023 When reset=0, SHALL asynchronously force the state to IDLE, set gnt=0, busy=0, done=0, done_id=0 and match_cnt=0, set the last-served pointer to 1, and clear the detector to its start state.
REQ-024 Reset asserted mid-SCAN SHALL abort the job without issuing done; the requester re-requests afterward.

Configuration
REQ-025 With macro SCAN_FIRST_POS_EN defined, SHALL add output first_pos[3:0]: the bit index that completed the first match of the job, or 4'hF if there was none, valid with done, and reset to 4'hF.
REQ-026 Without SCAN_FIRST_POS_EN, the first_pos port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 A shared package SHALL hold the FSM state encodings (IDLE/SCAN/DONE), the detector state encodings, and the constant pattern 4'b1001.
REQ-028 The detector SHALL be a sub-module named seq1001_det (clock, reset, clr, x, z) instantiated once.

Verification
REQ-029 After reset, req=2'b01, data0=8'b1001_0010 -> gnt=01, then 8 SCAN cycles, then done=1, done_id=0, match_cnt=2, first_pos=3.
REQ-030 req=2'b11 in the first cycle after reset -> gnt=01 first, then gnt=10 in the cycle after DONE; data1=8'hFF -> match_cnt=0, first_pos=4'hF.
REQ-031 data0=8'b1001_1001 -> match_cnt=2 (at indices 3 and 7); a following job data0=8'b0010_0000 -> match_cnt=0, which proves the detector clear between jobs.
REQ-032 reset pulsed low at SCAN cycle 4 -> outputs return to reset values immediately, no done is issued, and the next req is granted normally.
REQ-033 req[1] toggled during SCAN -> no gnt until after DONE, and the result matches the captured word only.
